// File: rtl/ctrl_pipe_pkg.sv
// Shared control-bundle constants for the EX/M/WB pipeline: bit positions,
// bubble encodings and the MIPS opcodes the decoder recognises.
package ctrl_pkg;

  localparam int EX_REGDST   = 3;
  localparam int EX_ALUSRC   = 0;
  localparam int M_BRANCH    = 2;
  localparam int M_MEMRD     = 1;
  localparam int M_MEMWR     = 0;
  localparam int WB_REGWR    = 1;
  localparam int WB_MEMTOREG = 0;

  localparam logic [3:0] EX_NOP = 4'b0000;
  localparam logic [2:0] M_NOP  = 3'b000;
  localparam logic [1:0] WB_NOP = 2'b00;

  localparam logic [5:0] OP_RTYPE = 6'd0;
  localparam logic [5:0] OP_LW    = 6'd35;
  localparam logic [5:0] OP_SW    = 6'd43;
  localparam logic [5:0] OP_BEQ   = 6'd4;

endpackage

// File: rtl/ctrl_hazard.sv
// Load-use detector: a load sitting in EX whose destination matches either
// source field of the instruction in ID. Register 0 never creates a hazard.
module ctrl_hazard #(
  parameter int REG_W = 5
) (
  input  logic             ex_memread,
  input  logic [REG_W-1:0] ex_dest,
  input  logic [REG_W-1:0] id_rs,
  input  logic [REG_W-1:0] id_rt,
  output logic             load_use
);

  // rt is compared even for I-type consumers; a spurious stall is harmless.
  assign load_use = ex_memread & (ex_dest != '0) &
                    ((ex_dest == id_rs) | (ex_dest == id_rt));

endmodule

// File: rtl/ctrl_pipe.sv
// ID/EX, EX/MEM and MEM/WB control registers with load-use stall and
// taken-branch flush. Define CTRL_PIPE_CNT_EN to build the stall/flush counters.
module ctrl_pipe
  import ctrl_pkg::*;
#(
  parameter int REG_W = 5,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             id_valid,
  input  logic [3:0]       id_ex,
  input  logic [2:0]       id_m,
  input  logic [1:0]       id_wb,
  input  logic [REG_W-1:0] id_rs,
  input  logic [REG_W-1:0] id_rt,
  input  logic [REG_W-1:0] id_rd,
  input  logic             ex_zero,
  output logic [3:0]       ex_ctrl,
  output logic [2:0]       mem_ctrl,
  output logic [1:0]       wb_ctrl,
  output logic [REG_W-1:0] ex_dest,
  output logic [REG_W-1:0] mem_dest,
  output logic [REG_W-1:0] wb_dest,
  output logic             stall,
  output logic             flush_id,
  output logic             br_taken,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  logic [2:0]       ex_m;
  logic [1:0]       ex_wb;
  logic [1:0]       mem_wb;
  logic             mem_zero_q;
  logic [REG_W-1:0] id_dest;
  logic             load_use;
  logic             id_bubble;

  assign id_dest = id_ex[EX_REGDST] ? id_rd : id_rt;

  ctrl_hazard #(.REG_W(REG_W)) u_hazard (
    .ex_memread (ex_m[M_MEMRD]),
    .ex_dest    (ex_dest),
    .id_rs      (id_rs),
    .id_rt      (id_rt),
    .load_use   (load_use)
  );

  // A taken branch squashes the load-use consumer too, so the flush wins.
  assign br_taken  = mem_ctrl[M_BRANCH] & mem_zero_q;
  assign stall     = id_valid & load_use & ~br_taken;
  assign flush_id  = br_taken;
  assign id_bubble = br_taken | stall | ~id_valid;

  always_ff @(posedge clk) begin
    if (!rst) begin
      ex_ctrl    <= EX_NOP;
      ex_m       <= M_NOP;
      ex_wb      <= WB_NOP;
      ex_dest    <= '0;
      mem_ctrl   <= M_NOP;
      mem_wb     <= WB_NOP;
      mem_dest   <= '0;
      mem_zero_q <= 1'b0;
      wb_ctrl    <= WB_NOP;
      wb_dest    <= '0;
    end else begin
      wb_ctrl <= mem_wb;
      wb_dest <= mem_dest;

      if (br_taken) begin
        mem_ctrl   <= M_NOP;
        mem_wb     <= WB_NOP;
        mem_dest   <= '0;
        mem_zero_q <= 1'b0;
      end else begin
        mem_ctrl   <= ex_m;
        mem_wb     <= ex_wb;
        mem_dest   <= ex_dest;
        mem_zero_q <= ex_zero;
      end

      if (id_bubble) begin
        ex_ctrl <= EX_NOP;
        ex_m    <= M_NOP;
        ex_wb   <= WB_NOP;
        ex_dest <= '0;
      end else begin
        ex_ctrl <= id_ex;
        ex_m    <= id_m;
        ex_wb   <= id_wb;
        ex_dest <= id_dest;
      end
    end
  end

`ifdef CTRL_PIPE_CNT_EN
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  always_ff @(posedge clk) begin
    if (!rst) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (stall && (stall_cnt != '1)) stall_cnt <= stall_cnt + CNT_ONE;
      if (br_taken && (flush_cnt != '1)) flush_cnt <= flush_cnt + CNT_ONE;
    end
  end
`else
  assign stall_cnt = '0;
  assign flush_cnt = '0;
`endif

endmodule

// File: tb/tb_ctrl_pipe.sv
// Bench for ctrl_pipe: hand-derived vector table for the directed corner
// cases, then random instruction streams checked against an in-flight slot model.
module tb_ctrl_pipe;
  import ctrl_pkg::*;

  localparam int REG_W   = 5;
  localparam int CNT_W   = 3;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic             clk, rst, id_valid, ex_zero;
  logic [3:0]       id_ex;
  logic [2:0]       id_m;
  logic [1:0]       id_wb;
  logic [REG_W-1:0] id_rs, id_rt, id_rd;
  logic [3:0]       ex_ctrl;
  logic [2:0]       mem_ctrl;
  logic [1:0]       wb_ctrl;
  logic [REG_W-1:0] ex_dest, mem_dest, wb_dest;
  logic             stall, flush_id, br_taken;
  logic [CNT_W-1:0] stall_cnt, flush_cnt;

  ctrl_pipe #(.REG_W(REG_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_ex(id_ex), .id_m(id_m),
    .id_wb(id_wb), .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd),
    .ex_zero(ex_zero), .ex_ctrl(ex_ctrl), .mem_ctrl(mem_ctrl),
    .wb_ctrl(wb_ctrl), .ex_dest(ex_dest), .mem_dest(mem_dest),
    .wb_dest(wb_dest), .stall(stall), .flush_id(flush_id),
    .br_taken(br_taken), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Decoder truth table, written from the opcode meaning.
  task automatic decode(input logic [5:0] op, output logic [3:0] ex,
                        output logic [2:0] m, output logic [1:0] wb);
    ex = EX_NOP; m = M_NOP; wb = WB_NOP;
    case (op)
      OP_RTYPE: begin ex[EX_REGDST] = 1'b1; ex[2] = 1'b1; wb[WB_REGWR] = 1'b1; end
      OP_LW: begin
        ex[EX_ALUSRC] = 1'b1; m[M_MEMRD] = 1'b1;
        wb[WB_REGWR] = 1'b1; wb[WB_MEMTOREG] = 1'b1;
      end
      OP_SW:  begin ex[EX_ALUSRC] = 1'b1; m[M_MEMWR] = 1'b1; end
      OP_BEQ: begin ex[1] = 1'b1; m[M_BRANCH] = 1'b1; end
      default: ;
    endcase
  endtask

  // Reference model: which instruction occupies each stage.
  typedef struct {
    logic [3:0]       ex;
    logic [2:0]       m;
    logic [1:0]       wb;
    logic [REG_W-1:0] dest;
  } slot_t;

  slot_t s_ex, s_mem, s_wb, s_nop;
  logic  m_zero;
  int    m_stall_cnt, m_flush_cnt;

  function automatic logic m_br();
    return s_mem.m[M_BRANCH] && m_zero;
  endfunction

  function automatic logic m_stall();
    logic hit;
    hit = s_ex.m[M_MEMRD] && (s_ex.dest != 0) && ((s_ex.dest == id_rs) || (s_ex.dest == id_rt));
    return id_valid && hit && !m_br();
  endfunction

  task automatic model_step();
    logic br, st;
    if (!rst) begin
      s_ex = s_nop; s_mem = s_nop; s_wb = s_nop; m_zero = 1'b0;
      m_stall_cnt = 0; m_flush_cnt = 0;
    end else begin
      br = m_br();
      st = m_stall();
      if (st && m_stall_cnt < CNT_MAX) m_stall_cnt++;
      if (br && m_flush_cnt < CNT_MAX) m_flush_cnt++;
      s_wb   = s_mem;
      s_mem  = br ? s_nop : s_ex;
      m_zero = br ? 1'b0 : ex_zero;
      if (br || st || !id_valid) s_ex = s_nop;
      else s_ex = '{id_ex, id_m, id_wb, id_ex[EX_REGDST] ? id_rd : id_rt};
    end
  endtask

  task automatic apply(input logic r, input logic v, input logic [5:0] op,
                       input logic [REG_W-1:0] rs, input logic [REG_W-1:0] rt,
                       input logic [REG_W-1:0] rd, input logic z);
    logic [3:0] e; logic [2:0] m; logic [1:0] w;
    decode(op, e, m, w);
    rst = r; id_valid = v; id_ex = e; id_m = m; id_wb = w;
    id_rs = rs; id_rt = rt; id_rd = rd; ex_zero = z;
    #1;
  endtask

  task automatic chk_counters(input string tag);
`ifdef CTRL_PIPE_CNT_EN
    chk({tag, " stall_cnt"}, 32'(stall_cnt), 32'(m_stall_cnt));
    chk({tag, " flush_cnt"}, 32'(flush_cnt), 32'(m_flush_cnt));
`else
    chk({tag, " stall_cnt"}, 32'(stall_cnt), 32'd0);
    chk({tag, " flush_cnt"}, 32'(flush_cnt), 32'd0);
`endif
  endtask

  task automatic clock_edge();
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask

  typedef struct {
    logic r, v; logic [5:0] op; logic [4:0] rs, rt, rd; logic z;
    logic [3:0] e_ex; logic [2:0] e_mem; logic [1:0] e_wb;
    logic [4:0] e_exd, e_memd, e_wbd; logic e_stall, e_br;
  } vec_t;

  vec_t vq[$];

  localparam logic [3:0] RX = 4'b1100;
  localparam logic [3:0] LX = 4'b0001;
  localparam logic [3:0] BX = 4'b0010;

  initial begin
    logic hold;
    logic [5:0] ops [4];
    logic       r_v, v_v, z_v;
    logic [5:0] op_v;
    logic [4:0] rs_v, rt_v, rd_v;

    s_nop = '{EX_NOP, M_NOP, WB_NOP, '0};
    s_ex = s_nop; s_mem = s_nop; s_wb = s_nop; m_zero = 1'b0;
    m_stall_cnt = 0; m_flush_cnt = 0;
    apply(1'b0, 1'b0, OP_RTYPE, 0, 0, 0, 1'b0);
    repeat (2) @(posedge clk);
    @(negedge clk);

    //            r  v  op       rs rt rd z  | ex  mem     wb     exd memd wbd st br
    vq.push_back('{0, 0, OP_RTYPE, 0, 0, 0, 0, 0,  3'b000, 2'b00, 0, 0, 0, 0, 0});
    vq.push_back('{1, 1, OP_RTYPE, 1, 2, 3, 0, 0,  3'b000, 2'b00, 0, 0, 0, 0, 0});
    vq.push_back('{1, 0, OP_RTYPE, 0, 0, 0, 0, RX, 3'b000, 2'b00, 3, 0, 0, 0, 0});
    vq.push_back('{1, 0, OP_RTYPE, 0, 0, 0, 0, 0,  3'b000, 2'b00, 0, 3, 0, 0, 0});
    vq.push_back('{1, 0, OP_RTYPE, 0, 0, 0, 0, 0,  3'b000, 2'b10, 0, 0, 3, 0, 0});
    vq.push_back('{1, 1, OP_LW,    1, 5, 7, 0, 0,  3'b000, 2'b00, 0, 0, 0, 0, 0});
    vq.push_back('{1, 1, OP_RTYPE, 5, 2, 4, 0, LX, 3'b000, 2'b00, 5, 0, 0, 1, 0});
    vq.push_back('{1, 1, OP_RTYPE, 5, 2, 4, 0, 0,  3'b010, 2'b00, 0, 5, 0, 0, 0});
    vq.push_back('{1, 0, OP_RTYPE, 0, 0, 0, 0, RX, 3'b000, 2'b11, 4, 0, 5, 0, 0});
    vq.push_back('{1, 1, OP_LW,    2, 0, 9, 0, 0,  3'b000, 2'b00, 0, 4, 0, 0, 0});
    vq.push_back('{1, 1, OP_RTYPE, 0, 0, 6, 0, LX, 3'b000, 2'b10, 0, 0, 4, 0, 0});
    vq.push_back('{1, 0, OP_RTYPE, 0, 0, 0, 0, RX, 3'b010, 2'b00, 6, 0, 0, 0, 0});
    vq.push_back('{1, 0, OP_RTYPE, 0, 0, 0, 0, 0,  3'b000, 2'b11, 0, 6, 0, 0, 0});
    vq.push_back('{1, 1, OP_BEQ,   1, 2, 0, 0, 0,  3'b000, 2'b10, 0, 0, 6, 0, 0});
    vq.push_back('{1, 1, OP_RTYPE, 3, 4, 8, 1, BX, 3'b000, 2'b00, 2, 0, 0, 0, 0});
    vq.push_back('{1, 1, OP_RTYPE, 1, 1, 9, 0, RX, 3'b100, 2'b00, 8, 2, 0, 0, 1});
    vq.push_back('{1, 0, OP_RTYPE, 0, 0, 0, 0, 0,  3'b000, 2'b00, 0, 0, 2, 0, 0});
    vq.push_back('{1, 1, OP_BEQ,   1, 2, 0, 0, 0,  3'b000, 2'b00, 0, 0, 0, 0, 0});
    vq.push_back('{1, 1, OP_RTYPE, 3, 4, 8, 0, BX, 3'b000, 2'b00, 2, 0, 0, 0, 0});
    vq.push_back('{1, 0, OP_RTYPE, 0, 0, 0, 0, RX, 3'b100, 2'b00, 8, 2, 0, 0, 0});
    vq.push_back('{1, 0, OP_RTYPE, 0, 0, 0, 0, 0,  3'b000, 2'b00, 0, 8, 2, 0, 0});
    vq.push_back('{1, 1, OP_BEQ,   1, 2, 0, 0, 0,  3'b000, 2'b10, 0, 0, 8, 0, 0});
    vq.push_back('{1, 1, OP_LW,    1, 5, 0, 1, BX, 3'b000, 2'b00, 2, 0, 0, 0, 0});
    vq.push_back('{1, 1, OP_RTYPE, 5, 0, 3, 0, LX, 3'b100, 2'b00, 5, 2, 0, 0, 1});
    vq.push_back('{1, 0, OP_RTYPE, 0, 0, 0, 0, 0,  3'b000, 2'b00, 0, 0, 2, 0, 0});
    vq.push_back('{1, 1, OP_RTYPE, 1, 2, 3, 0, 0,  3'b000, 2'b00, 0, 0, 0, 0, 0});
    vq.push_back('{1, 1, OP_RTYPE, 1, 2, 4, 0, RX, 3'b000, 2'b00, 3, 0, 0, 0, 0});
    vq.push_back('{1, 1, OP_RTYPE, 1, 2, 5, 0, RX, 3'b000, 2'b00, 4, 3, 0, 0, 0});
    vq.push_back('{0, 1, OP_RTYPE, 1, 2, 6, 0, RX, 3'b000, 2'b10, 5, 4, 3, 0, 0});
    vq.push_back('{0, 1, OP_RTYPE, 1, 2, 6, 0, 0,  3'b000, 2'b00, 0, 0, 0, 0, 0});
    vq.push_back('{1, 0, OP_RTYPE, 0, 0, 0, 0, 0,  3'b000, 2'b00, 0, 0, 0, 0, 0});

    foreach (vq[i]) begin
      string t;
      t = $sformatf("vec%0d", i);
      apply(vq[i].r, vq[i].v, vq[i].op, vq[i].rs, vq[i].rt, vq[i].rd, vq[i].z);
      chk({t, " ex_ctrl"},  32'(ex_ctrl),  32'(vq[i].e_ex));
      chk({t, " mem_ctrl"}, 32'(mem_ctrl), 32'(vq[i].e_mem));
      chk({t, " wb_ctrl"},  32'(wb_ctrl),  32'(vq[i].e_wb));
      chk({t, " ex_dest"},  32'(ex_dest),  32'(vq[i].e_exd));
      chk({t, " mem_dest"}, 32'(mem_dest), 32'(vq[i].e_memd));
      chk({t, " wb_dest"},  32'(wb_dest),  32'(vq[i].e_wbd));
      chk({t, " stall"},    32'(stall),    32'(vq[i].e_stall));
      chk({t, " br_taken"}, 32'(br_taken), 32'(vq[i].e_br));
      chk({t, " flush_id"}, 32'(flush_id), 32'(vq[i].e_br));
      chk_counters(t);
      $display("vec%0d rst=%0b v=%0b op=%0d rs=%0d rt=%0d -> ex=%b mem=%b wb=%b stall=%0b br=%0b",
               i, vq[i].r, vq[i].v, vq[i].op, vq[i].rs, vq[i].rt, ex_ctrl, mem_ctrl, wb_ctrl, stall, br_taken);
      clock_edge();
    end

    ops[0] = OP_RTYPE; ops[1] = OP_LW; ops[2] = OP_SW; ops[3] = OP_BEQ;
    hold = 1'b0;
    r_v = 1'b1; v_v = 1'b1; z_v = 1'b0; op_v = OP_RTYPE; rs_v = 0; rt_v = 0; rd_v = 0;
    for (int n = 0; n < 600; n++) begin
      string t;
      t = $sformatf("rnd%0d", n);
      r_v = ($urandom_range(0, 59) != 0);
      z_v = $urandom_range(0, 1) != 0;
      if (!hold) begin
        v_v  = ($urandom_range(0, 9) != 0);
        op_v = ops[$urandom_range(0, 3)];
        rs_v = 5'($urandom_range(0, 3));
        rt_v = 5'($urandom_range(0, 3));
        rd_v = 5'($urandom_range(0, 3));
      end
      apply(r_v, v_v, op_v, rs_v, rt_v, rd_v, z_v);
      chk({t, " ex_ctrl"},  32'(ex_ctrl),  32'(s_ex.ex));
      chk({t, " mem_ctrl"}, 32'(mem_ctrl), 32'(s_mem.m));
      chk({t, " wb_ctrl"},  32'(wb_ctrl),  32'(s_wb.wb));
      chk({t, " ex_dest"},  32'(ex_dest),  32'(s_ex.dest));
      chk({t, " mem_dest"}, 32'(mem_dest), 32'(s_mem.dest));
      chk({t, " wb_dest"},  32'(wb_dest),  32'(s_wb.dest));
      chk({t, " stall"},    32'(stall),    32'(m_stall()));
      chk({t, " br_taken"}, 32'(br_taken), 32'(m_br()));
      chk({t, " flush_id"}, 32'(flush_id), 32'(m_br()));
      chk_counters(t);
      $display("rnd%0d rst=%0b v=%0b op=%0d rs=%0d rt=%0d -> ex=%b mem=%b wb=%b stall=%0b br=%0b",
               n, r_v, v_v, op_v, rs_v, rt_v, ex_ctrl, mem_ctrl, wb_ctrl, stall, br_taken);
      hold = r_v && m_stall();
      clock_edge();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
